// File: rtl/fp_divider_seq_if.sv
// Handshake/data bundle for fp_divider_seq.
//   master : operand source + result consumer (drives in_valid, a, b, out_ready)
//   slave  : the divider (drives in_ready, out_valid, q, flag_*)
// Port summary:
//   in_valid/in_ready   operand handshake
//   a, b                dividend / divisor, {sign, exponent, mantissa}
//   out_valid/out_ready result handshake
//   q                   quotient
//   flag_nv/dz/of/uf    invalid, divide-by-zero, overflow, underflow
interface fp_divider_seq_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         flag_nv;
  logic         flag_dz;
  logic         flag_of;
  logic         flag_uf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, flag_nv, flag_dz, flag_of, flag_uf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, flag_nv, flag_dz, flag_of, flag_uf
  );
endinterface

// File: rtl/fp_divider_seq.sv
// Iterative floating-point divider q = a / b for an EXP_W/MAN_W format.
// Radix-2 restoring division of the significands (MAN_W+3 quotient bits),
// round-to-nearest-even, subnormals flushed to zero, special cases resolved
// at accept time without entering the divide loop.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (aborts any operation in flight)
//   bus  fp_divider_seq_if.slave: in_valid/in_ready/a/b, out_valid/out_ready/q,
//        flag_nv/flag_dz/flag_of/flag_uf
// Latency: specials 1 cycle after accept, normal operands MAN_W+5 cycles.
module fp_divider_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic              clk,
  input logic              rst,
  fp_divider_seq_if.slave  bus
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(N);
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t state, state_next;

  // operand fields
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  logic               a_zero, a_inf, a_nan;
  logic               b_zero, b_inf, b_nan;

  assign {sa, ea, ma} = bus.a;
  assign {sb, eb, mb} = bus.b;

  // exponent 0 covers both true zero and subnormals (flushed)
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);

  // special-case resolution
  logic         spec_hit;
  logic [W-1:0] spec_q;
  logic         spec_nv, spec_dz;
  logic         s_res;

  assign s_res = sa ^ sb;

  always_comb begin
    spec_hit = 1'b0;
    spec_q   = '0;
    spec_nv  = 1'b0;
    spec_dz  = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_hit = 1'b1;
      spec_q   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_nv  = 1'b1;
    end else if (a_inf) begin
      spec_hit = 1'b1;
      spec_q   = {s_res, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_hit = 1'b1;
      spec_q   = {s_res, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_dz  = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_hit = 1'b1;
      spec_q   = {s_res, {(W-1){1'b0}}};
    end
  end

  // datapath state
  logic                  sign;
  logic [MAN_W:0]        div_r;
  logic [MAN_W+1:0]      rem;
  logic [N-1:0]          quo;
  logic [CW-1:0]         cnt;
  logic signed [EW-1:0]  exp_tmp;
  logic [W-1:0]          q_r;
  logic                  nv_r, dz_r, of_r, uf_r;

  // FSM next-state and handshake outputs
  logic in_ready, out_valid, accept;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = spec_hit ? DONE : DIV;
        end
      end
      DIV:  if (cnt == '0) state_next = NORM;
      NORM: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // one restoring step: the partial remainder is always below 2*divisor,
  // so the difference fits in MAN_W+1 bits before the doubling shift
  logic [MAN_W+1:0] div_ext;
  logic             ge;
  logic [MAN_W:0]   rem_sub;

  assign div_ext = {1'b0, div_r};
  assign ge      = (rem >= div_ext);
  assign rem_sub = ge ? (MAN_W+1)'(rem - div_ext) : rem[MAN_W:0];

  // normalise, round, range-check
  logic [MAN_W:0]       mant;
  logic                 guard, sticky, round_up;
  logic [MAN_W+1:0]     mant_r;
  logic signed [EW-1:0] exp_n, exp_r;
  logic [MAN_W-1:0]     frac;
  logic                 norm_of, norm_uf;
  logic [W-1:0]         norm_q;

  always_comb begin
    if (quo[N-1]) begin
      mant   = quo[N-1:2];
      guard  = quo[1];
      sticky = quo[0] | (rem != '0);
      exp_n  = exp_tmp;
    end else begin
      mant   = quo[N-2:1];
      guard  = quo[0];
      sticky = (rem != '0);
      exp_n  = exp_tmp - EW'(1);
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + (MAN_W+2)'(round_up);
    // carry out of the significand leaves 10..0: fraction is zero, bump exponent
    if (mant_r[MAN_W+1]) begin
      exp_r = exp_n + EW'(1);
      frac  = mant_r[MAN_W:1];
    end else begin
      exp_r = exp_n;
      frac  = mant_r[MAN_W-1:0];
    end
    norm_of = !exp_r[EW-1] && (exp_r >= EXP_MAX);
    norm_uf = exp_r[EW-1] || (exp_r == '0);
    if (norm_of)      norm_q = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (norm_uf) norm_q = {sign, {(W-1){1'b0}}};
    else              norm_q = {sign, exp_r[EXP_W-1:0], frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign    <= 1'b0;
      div_r   <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      exp_tmp <= '0;
      q_r     <= '0;
      nv_r    <= 1'b0;
      dz_r    <= 1'b0;
      of_r    <= 1'b0;
      uf_r    <= 1'b0;
    end else begin
      if (accept) begin
        sign    <= s_res;
        div_r   <= {1'b1, mb};
        rem     <= {1'b0, 1'b1, ma};
        quo     <= '0;
        cnt     <= CW'(N - 1);
        exp_tmp <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
        nv_r    <= spec_nv;
        dz_r    <= spec_dz;
        of_r    <= 1'b0;
        uf_r    <= 1'b0;
        if (spec_hit) q_r <= spec_q;
      end
      if (state == DIV) begin
        rem <= {rem_sub, 1'b0};
        quo <= {quo[N-2:0], ge};
        cnt <= cnt - CW'(1);
      end
      if (state == NORM) begin
        q_r  <= norm_q;
        of_r <= norm_of;
        uf_r <= norm_uf;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.q         = q_r;
  assign bus.flag_nv   = nv_r;
  assign bus.flag_dz   = dz_r;
  assign bus.flag_of   = of_r;
  assign bus.flag_uf   = uf_r;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed bench for fp_divider_seq in its default FP16 (E5M10) configuration.
module tb_fp_divider_seq;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fp_divider_seq_if #(.EXP_W(5), .MAN_W(10)) bus ();

  fp_divider_seq #(.EXP_W(5), .MAN_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Issue one operation, wait for the result, capture it, complete the
  // output handshake. lat counts rising edges from the accept edge through
  // the edge that raises out_valid; 100 means it never came.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        output logic [15:0] qv, output logic [3:0] fl,
                        output int lat);
    int g;
    @(negedge clk);
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    qv = bus.q;
    fl = {bus.flag_nv, bus.flag_dz, bus.flag_of, bus.flag_uf};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    vectors++;
    if (bus.q !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_q got=%h exp=0000", bus.q);
    end
    vectors++;
    if ({bus.flag_nv, bus.flag_dz, bus.flag_of, bus.flag_uf} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.flag_nv, bus.flag_dz, bus.flag_of, bus.flag_uf});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // finite/finite results; flags order {nv,dz,of,uf}
  task automatic test_normal;
    logic [15:0] ta [5] = '{16'h3C00, 16'h4600, 16'h4500, 16'h3C00, 16'h3C00};
    logic [15:0] tb [5] = '{16'h4200, 16'hC000, 16'h4200, 16'h3D00, 16'h3BFF};
    logic [15:0] tq [5] = '{16'h3555, 16'hC200, 16'h3EAB, 16'h3A66, 16'h3C01};
    logic [15:0] qv;
    logic [3:0]  fl;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], qv, fl, lat);
      vectors++;
      if (qv !== tq[i]) begin
        miscompares++;
        $display("FAIL normal_q[%0d] %h/%h got=%h exp=%h", i, ta[i], tb[i], qv, tq[i]);
      end
      vectors++;
      if (fl !== 4'b0000) begin
        miscompares++;
        $display("FAIL normal_flags[%0d] got=%b exp=0000", i, fl);
      end
      vectors++;
      if (lat !== 15) begin
        miscompares++;
        $display("FAIL normal_latency[%0d] got=%0d exp=15", i, lat);
      end
    end
  endtask

  task automatic test_specials;
    logic [15:0] ta [9] = '{16'h3C00, 16'h0000, 16'h7C00, 16'h7E01, 16'hFC00,
                            16'h7C00, 16'h0000, 16'h4200, 16'hBC00};
    logic [15:0] tb [9] = '{16'h0000, 16'h0000, 16'h7C00, 16'h3C00, 16'h4000,
                            16'h0000, 16'hC000, 16'hFC00, 16'h0001};
    logic [15:0] tq [9] = '{16'h7C00, 16'h7E00, 16'h7E00, 16'h7E00, 16'hFC00,
                            16'h7C00, 16'h8000, 16'h8000, 16'hFC00};
    logic [3:0]  tf [9] = '{4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                            4'b0000, 4'b0000, 4'b0000, 4'b0100};
    logic [15:0] qv;
    logic [3:0]  fl;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      run_op(ta[i], tb[i], qv, fl, lat);
      vectors++;
      if (qv !== tq[i]) begin
        miscompares++;
        $display("FAIL special_q[%0d] %h/%h got=%h exp=%h", i, ta[i], tb[i], qv, tq[i]);
      end
      vectors++;
      if (fl !== tf[i]) begin
        miscompares++;
        $display("FAIL special_flags[%0d] got=%b exp=%b", i, fl, tf[i]);
      end
      vectors++;
      if (lat !== 1) begin
        miscompares++;
        $display("FAIL special_latency[%0d] got=%0d exp=1", i, lat);
      end
    end
  endtask

  task automatic test_range;
    logic [15:0] qv;
    logic [3:0]  fl;
    int          lat;
    run_op(16'h7BFF, 16'h1400, qv, fl, lat);
    vectors++;
    if (qv !== 16'h7C00 || fl !== 4'b0010) begin
      miscompares++;
      $display("FAIL overflow got=%h/%b exp=7c00/0010", qv, fl);
    end
    run_op(16'h0400, 16'h7800, qv, fl, lat);
    vectors++;
    if (qv !== 16'h0000 || fl !== 4'b0001) begin
      miscompares++;
      $display("FAIL underflow got=%h/%b exp=0000/0001", qv, fl);
    end
    // flags from the previous result must not persist
    run_op(16'h3C00, 16'h4200, qv, fl, lat);
    vectors++;
    if (qv !== 16'h3555 || fl !== 4'b0000) begin
      miscompares++;
      $display("FAIL flags_clear got=%h/%b exp=3555/0000", qv, fl);
    end
  endtask

  task automatic test_hold;
    int lat;
    @(negedge clk);
    bus.a = 16'h4600;
    bus.b = 16'hC000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat !== 15) begin
      miscompares++;
      $display("FAIL hold_latency got=%0d exp=15", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.q !== 16'hC200 ||
          {bus.flag_nv, bus.flag_dz, bus.flag_of, bus.flag_uf} !== 4'b0000) begin
        miscompares++;
        $display("FAIL hold_stable[%0d] got ov=%b ir=%b q=%h exp ov=1 ir=0 q=c200",
                 i, bus.out_valid, bus.in_ready, bus.q);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release got ov=%b ir=%b exp ov=0 ir=1", bus.out_valid, bus.in_ready);
    end
  endtask

  // operands presented while busy must be ignored
  task automatic test_busy_ignore;
    int lat;
    @(negedge clk);
    bus.a = 16'h3C00;
    bus.b = 16'h4200;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 16'h3C00;
    bus.b = 16'h0000;
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      lat++;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_in_ready[%0d] got=%b exp=0", i, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (bus.q !== 16'h3555 || bus.flag_dz !== 1'b0 || lat !== 15) begin
      miscompares++;
      $display("FAIL busy_result got q=%h dz=%b lat=%0d exp q=3555 dz=0 lat=15",
               bus.q, bus.flag_dz, lat);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_div;
    logic [15:0] qv;
    logic [3:0]  fl;
    int          lat;
    @(negedge clk);
    bus.a = 16'h4600;
    bus.b = 16'hC000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.q !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid got ov=%b ir=%b q=%h exp ov=0 ir=1 q=0000",
               bus.out_valid, bus.in_ready, bus.q);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h3C00, 16'h4200, qv, fl, lat);
    vectors++;
    if (qv !== 16'h3555 || fl !== 4'b0000 || lat !== 15) begin
      miscompares++;
      $display("FAIL after_reset got q=%h fl=%b lat=%0d exp q=3555 fl=0000 lat=15", qv, fl, lat);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_specials;
    test_range;
    test_hold;
    test_busy_ignore;
    test_reset_mid_div;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
